draw_square_arbiter: RTL and testbench

Shares one draw_square engine, and through it the single VGA write port, among NUM_REQ independent requesters (player sprite, HUD, map tiles, etc.). It arbitrates pending requests round-robin, latches the winner's corner and colour, and pulses the engine's start. It then waits for the engine's done pulse and returns a one-cycle acknowledge to the winner. A watchdog aborts a job if the engine never reports done.

---
 rtl/draw_square_arbiter.sv | 111 +++++++++++
 tb/tb_draw_square_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_square_arbiter.sv
// Round-robin arbiter sharing one draw_square engine among NUM_REQ requesters.
// Latches the winner's corner/colour, starts the engine, and acks on done or timeout.
module draw_square_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [9*NUM_REQ-1:0]   req_x,
    input  logic [8*NUM_REQ-1:0]   req_y,
    input  logic [3*NUM_REQ-1:0]   req_colour,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   error,
    output logic                   busy,
    output logic [ID_W-1:0]        grant_id,
    output logic                   engine_start,
    input  logic                   engine_done,
    output logic [8:0]             engine_x,
    output logic [7:0]             engine_y,
    output logic [2:0]             engine_colour
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        ACK       = 2'd3
    } state_t;

    state_t          state, state_next;
    logic [ID_W-1:0] last;
    logic [ID_W-1:0] winner;
    logic            found;
    logic [TO_W-1:0] watchdog;
    logic            err_flag;
    logic            timed_out;

    assign timed_out = (watchdog == TO_W'(TIMEOUT - 1));

    // Search starts one past the last winner so a just-served requester goes to the back.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        winner = '0;
        found  = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found && req[(int'(last) + i) % NUM_REQ]) begin
                found  = 1'b1;
                winner = ID_W'((int'(last) + i) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        // NOTE: registered state uses non-blocking assignments so all flops update from pre-edge values.
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (|req) state_next = ISSUE;
            ISSUE:     state_next = WAIT_DONE;
            WAIT_DONE: if (engine_done || timed_out) state_next = ACK;
            ACK:       state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grant_id      <= '0;
            last          <= ID_W'(NUM_REQ - 1);
            engine_x      <= '0;
            engine_y      <= '0;
            engine_colour <= '0;
            watchdog      <= '0;
            err_flag      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant_id      <= winner;
                        last          <= winner;
                        engine_x      <= req_x[9*int'(winner) +: 9];
                        engine_y      <= req_y[8*int'(winner) +: 8];
                        engine_colour <= req_colour[3*int'(winner) +: 3];
                    end
                end
                ISSUE: watchdog <= '0;
                WAIT_DONE: begin
                    watchdog <= watchdog + 1'b1;
                    // Done in the same cycle as the timeout still counts as success.
                    err_flag <= !engine_done;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        engine_start = (state == ISSUE);
        busy         = (state != IDLE);
        ack          = (state == ACK) ? (NUM_REQ'(1) << grant_id) : '0;
        error        = (state == ACK) && err_flag;
    end

endmodule

// File: tb/tb_draw_square_arbiter.sv
// Directed bench for draw_square_arbiter with an engine model and a start/ack scoreboard.
module tb_draw_square_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 64;
    localparam int TO_W    = 7;

    logic                 clock;
    logic                 reset;
    logic [NUM_REQ-1:0]   req;
    logic [9*NUM_REQ-1:0] req_x;
    logic [8*NUM_REQ-1:0] req_y;
    logic [3*NUM_REQ-1:0] req_colour;
    logic [NUM_REQ-1:0]   ack;
    logic                 error;
    logic                 busy;
    logic [ID_W-1:0]      grant_id;
    logic                 engine_start;
    logic                 engine_done;
    logic [8:0]           engine_x;
    logic [7:0]           engine_y;
    logic [2:0]           engine_colour;

    logic model_done;
    logic spurious;
    int   done_delay;
    int   eng_cnt;

    assign engine_done = model_done | spurious;

    draw_square_arbiter #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
    ) dut (
        .clock(clock), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
        .req_colour(req_colour), .ack(ack), .error(error), .busy(busy),
        .grant_id(grant_id), .engine_start(engine_start), .engine_done(engine_done),
        .engine_x(engine_x), .engine_y(engine_y), .engine_colour(engine_colour)
    );

    typedef struct {
        int          id;
        logic [8:0]  x;
        logic [7:0]  y;
        logic [2:0]  c;
    } start_t;

    typedef struct {
        int   id;
        logic err;
    } ack_t;

    start_t start_q[$];
    ack_t   ack_q[$];
    int     checks = 0;
    int     errors = 0;
    int     ack_count = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Engine model: done pulses done_delay negedges after start is seen; negative means never.
    initial begin
        model_done = 1'b0;
        eng_cnt    = -1;
        forever begin
            @(negedge clock);
            model_done = 1'b0;
            if (!reset) eng_cnt = -1;
            else if (engine_start) eng_cnt = done_delay;
            else if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    model_done = 1'b1;
                    eng_cnt    = -1;
                end
            end
        end
    end

    // Scoreboard: every start and every ack must match the next queued expectation.
    always @(negedge clock) begin
        if (engine_start) begin
            if (start_q.size() == 0) check("start_unexpected", 32'd1, 32'd0);
            else begin
                automatic start_t s = start_q.pop_front();
                check("start_id", 32'(grant_id), 32'(s.id));
                check("start_x", 32'(engine_x), 32'(s.x));
                check("start_y", 32'(engine_y), 32'(s.y));
                check("start_colour", 32'(engine_colour), 32'(s.c));
            end
        end
        if (ack != '0) begin
            ack_count++;
            if (ack_q.size() == 0) check("ack_unexpected", 32'(ack), 32'd0);
            else begin
                automatic ack_t a = ack_q.pop_front();
                automatic logic [NUM_REQ-1:0] oh = NUM_REQ'(1) << a.id;
                check("ack_onehot", 32'(ack), 32'(oh));
                check("ack_error", 32'(error), 32'(a.err));
            end
        end
    end

    task automatic wait_start(output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!engine_start && n < 300);
        if (!engine_start) check("start_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (ack == '0 && n < 300);
        if (ack == '0) check("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (busy) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic push_job(input int id, input logic err);
        start_t s;
        ack_t   a;
        s.id = id;
        s.x  = req_x[9*id +: 9];
        s.y  = req_y[8*id +: 8];
        s.c  = req_colour[3*id +: 3];
        a.id = id;
        a.err = err;
        start_q.push_back(s);
        ack_q.push_back(a);
    endtask

    initial begin
        int n;
        int base;
        reset      = 1'b0;
        req        = '0;
        req_x      = '0;
        req_y      = '0;
        req_colour = '0;
        spurious   = 1'b0;
        done_delay = 50;

        // Reset state
        @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(engine_start), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_xyc", {9'd0, engine_x, engine_y, engine_colour, 3'd0}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Single request, latency, stability of latched corner
        @(negedge clock);
        req_x[17:9]      = 9'd100;
        req_y[15:8]      = 8'd50;
        req_colour[5:3]  = 3'd5;
        push_job(1, 1'b0);
        req = 4'b0010;
        wait_start(n);
        check("single_latency", 32'(n), 32'd1);
        check("single_busy", 32'(busy), 32'd1);
        req_x[17:9] = 9'd7;
        wait_ack(n);
        check("single_ack_delay", 32'(n), 32'd51);
        check("single_x_stable", 32'(engine_x), 32'd100);
        req = '0;
        @(negedge clock);
        check("single_idle_busy", 32'(busy), 32'd0);

        // Fresh reset so the pointer starts at the last requester
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;

        // Round-robin with all requests held
        req_x      = {9'd13, 9'd12, 9'd11, 9'd10};
        req_y      = {8'd23, 8'd22, 8'd21, 8'd20};
        req_colour = {3'd3, 3'd2, 3'd1, 3'd0};
        done_delay = 5;
        base = ack_count;
        for (int k = 0; k < 6; k++) push_job(k % NUM_REQ, 1'b0);
        req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            wait_start(n);
            if (k == 5) req = '0;
        end
        wait_ack(n);
        wait_idle();
        check("rr_ack_count", 32'(ack_count - base), 32'd6);

        // Priority rotation: after serving 2, request 0 beats 2
        push_job(2, 1'b0);
        req = 4'b0100;
        wait_start(n);
        req = '0;
        wait_ack(n);
        wait_idle();
        @(negedge clock);
        push_job(0, 1'b0);
        push_job(2, 1'b0);
        req = 4'b0101;
        wait_start(n);
        check("prio_first", 32'(grant_id), 32'd0);
        req = 4'b0100;
        wait_start(n);
        check("prio_second", 32'(grant_id), 32'd2);
        req = '0;
        wait_ack(n);
        wait_idle();

        // Watchdog timeout without done
        @(negedge clock);
        done_delay = -1;
        push_job(3, 1'b1);
        req = 4'b1000;
        wait_start(n);
        req = '0;
        wait_ack(n);
        check("wd_delay", 32'(n), 32'(TIMEOUT + 1));
        check("wd_error", 32'(error), 32'd1);
        @(negedge clock);
        check("wd_idle", 32'(busy), 32'd0);

        // Done and timeout coincide: done wins
        done_delay = TIMEOUT;
        push_job(0, 1'b0);
        req = 4'b0001;
        wait_start(n);
        req = '0;
        wait_ack(n);
        check("wd_tie_delay", 32'(n), 32'(TIMEOUT + 1));
        check("wd_tie_error", 32'(error), 32'd0);
        wait_idle();

        // Spurious done while idle
        @(negedge clock);
        spurious = 1'b1;
        @(negedge clock);
        spurious = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("spurious_no_ack", 32'(ack), 32'd0);
            check("spurious_idle", 32'(busy), 32'd0);
        end

        // Async reset during WAIT_DONE abandons the job
        done_delay = -1;
        begin
            start_t s;
            s.id = 2; s.x = req_x[26:18]; s.y = req_y[23:16]; s.c = req_colour[8:6];
            start_q.push_back(s);
        end
        req = 4'b0100;
        wait_start(n);
        repeat (10) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_start", 32'(engine_start), 32'd0);
        check("arst_ack", 32'(ack), 32'd0);
        check("arst_grant", 32'(grant_id), 32'd0);
        @(negedge clock);
        done_delay = 5;
        req = 4'b0101;
        push_job(0, 1'b0);
        reset = 1'b1;
        wait_start(n);
        check("arst_first_grant", 32'(grant_id), 32'd0);
        req = '0;
        wait_ack(n);
        wait_idle();
        repeat (3) @(negedge clock);

        check("start_q_empty", 32'(start_q.size()), 32'd0);
        check("ack_q_empty", 32'(ack_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
